// File: rtl/decode_pipe_if.sv
// decode_pipe bus bundle: D-register inputs, forwarding sources, W write port, E-register outputs.
// Pure wiring, no latency of its own.
// E_bub travels here from the hazard unit; the slave side consumes it.
interface decode_pipe_if;
    // D register, from fetch
    logic [1:0]  D_stat;
    logic [3:0]  D_in_code;
    logic [3:0]  D_in_fun;
    logic [3:0]  D_ra;
    logic [3:0]  D_rb;
    logic [63:0] D_val_c;
    logic [63:0] D_val_p;
    // forwarding sources
    logic [3:0]  e_dst_e;
    logic [63:0] e_val_e;
    logic [3:0]  M_dst_e;
    logic [63:0] M_val_e;
    logic [3:0]  M_dst_m;
    logic [63:0] m_val_m;
    // write-back port, also a forwarding source
    logic [3:0]  W_dst_e;
    logic [63:0] W_val_e;
    logic [3:0]  W_dst_m;
    logic [63:0] W_val_m;
    // hazard control
    logic        E_bub;
    // decode outputs
    logic [3:0]  d_src_a;
    logic [3:0]  d_src_b;
    logic [1:0]  E_stat;
    logic [3:0]  E_in_code;
    logic [3:0]  E_in_fun;
    logic [63:0] E_val_c;
    logic [63:0] E_val_a;
    logic [63:0] E_val_b;
    logic [3:0]  E_dst_e;
    logic [3:0]  E_dst_m;
    logic [3:0]  E_src_a;
    logic [3:0]  E_src_b;

    // Driver side (fetch, later stages, hazard unit, or a bench)
    modport master (
        output D_stat, D_in_code, D_in_fun, D_ra, D_rb, D_val_c, D_val_p,
        output e_dst_e, e_val_e, M_dst_e, M_val_e, M_dst_m, m_val_m,
        output W_dst_e, W_val_e, W_dst_m, W_val_m, E_bub,
        input  d_src_a, d_src_b,
        input  E_stat, E_in_code, E_in_fun, E_val_c, E_val_a, E_val_b,
        input  E_dst_e, E_dst_m, E_src_a, E_src_b
    );

    // Decode stage side
    modport slave (
        input  D_stat, D_in_code, D_in_fun, D_ra, D_rb, D_val_c, D_val_p,
        input  e_dst_e, e_val_e, M_dst_e, M_val_e, M_dst_m, m_val_m,
        input  W_dst_e, W_val_e, W_dst_m, W_val_m, E_bub,
        output d_src_a, d_src_b,
        output E_stat, E_in_code, E_in_fun, E_val_c, E_val_a, E_val_b,
        output E_dst_e, E_dst_m, E_src_a, E_src_b
    );
endinterface

// File: rtl/decode_pipe.sv
// Y86-64 decode/write-back: register file, src/dst ID generation, val_a/val_b forwarding, E register.
// One cycle D to E; d_src_a/d_src_b are combinational. Forwarding chain enabled by DECODE_FWD_EN.
// No stall input: E_bub replaces the captured instruction with a nop bubble; stalls live upstream.
module decode_pipe #(
    parameter logic [63:0] STACK_INIT = 64'd1000
) (
    input  logic         clock,
    input  logic         reset,
    decode_pipe_if.slave bus
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    logic [63:0] regs [0:14];
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] rd_a;
    logic [63:0] rd_b;
    logic [63:0] val_a;
    logic [63:0] val_b;

    // Register ID generation from the instruction code
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (bus.D_in_code)
            4'h2, 4'h4, 4'h6, 4'hA: src_a = bus.D_ra;
            4'h9, 4'hB:             src_a = RRSP;
            default:                src_a = RNONE;
        endcase
        case (bus.D_in_code)
            4'h4, 4'h5, 4'h6:       src_b = bus.D_rb;
            4'h8, 4'h9, 4'hA, 4'hB: src_b = RRSP;
            default:                src_b = RNONE;
        endcase
        // cmov still names rB here; execute cancels it when the condition fails
        case (bus.D_in_code)
            4'h2, 4'h3, 4'h6:       dst_e = bus.D_rb;
            4'h8, 4'h9, 4'hA, 4'hB: dst_e = RRSP;
            default:                dst_e = RNONE;
        endcase
        case (bus.D_in_code)
            4'h5, 4'hB: dst_m = bus.D_ra;
            default:    dst_m = RNONE;
        endcase
    end

    assign bus.d_src_a = src_a;
    assign bus.d_src_b = src_b;

    // Register file read ports; ID F reads as zero and never indexes the array
    always_comb begin
        rd_a = (src_a == RNONE) ? 64'd0 : regs[src_a];
        rd_b = (src_b == RNONE) ? 64'd0 : regs[src_b];
    end

`ifdef DECODE_FWD_EN
    // Operand selection: youngest producer wins, valM ahead of valE within a stage
    always_comb begin
        val_a = rd_a;
        val_b = rd_b;
        if (bus.D_in_code == 4'h7 || bus.D_in_code == 4'h8)
            val_a = bus.D_val_p;
        else if (src_a != RNONE && src_a == bus.e_dst_e)
            val_a = bus.e_val_e;
        else if (src_a != RNONE && src_a == bus.M_dst_m)
            val_a = bus.m_val_m;
        else if (src_a != RNONE && src_a == bus.M_dst_e)
            val_a = bus.M_val_e;
        else if (src_a != RNONE && src_a == bus.W_dst_m)
            val_a = bus.W_val_m;
        else if (src_a != RNONE && src_a == bus.W_dst_e)
            val_a = bus.W_val_e;

        if (src_b != RNONE && src_b == bus.e_dst_e)
            val_b = bus.e_val_e;
        else if (src_b != RNONE && src_b == bus.M_dst_m)
            val_b = bus.m_val_m;
        else if (src_b != RNONE && src_b == bus.M_dst_e)
            val_b = bus.M_val_e;
        else if (src_b != RNONE && src_b == bus.W_dst_m)
            val_b = bus.W_val_m;
        else if (src_b != RNONE && src_b == bus.W_dst_e)
            val_b = bus.W_val_e;
    end
`else
    // Operand selection without bypass: the hazard unit holds decode until write-back lands
    always_comb begin
        val_a = rd_a;
        val_b = rd_b;
        if (bus.D_in_code == 4'h7 || bus.D_in_code == 4'h8)
            val_a = bus.D_val_p;
    end

    logic unused_fwd;
    assign unused_fwd = ^{bus.e_dst_e, bus.e_val_e, bus.M_dst_e, bus.M_val_e,
                          bus.M_dst_m, bus.m_val_m};
`endif

    // Register file: valM is written last so it wins a same-register collision
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= (i == 4) ? STACK_INIT : 64'd0;
        end else begin
            if (bus.W_dst_e != RNONE)
                regs[bus.W_dst_e] <= bus.W_val_e;
            if (bus.W_dst_m != RNONE)
                regs[bus.W_dst_m] <= bus.W_val_m;
        end
    end

    // E pipeline register: reset and E_bub both load the nop bubble
    always_ff @(posedge clock or posedge reset) begin
        if (reset || bus.E_bub) begin
            bus.E_stat    <= 2'b00;
            bus.E_in_code <= 4'h1;
            bus.E_in_fun  <= 4'h0;
            bus.E_val_c   <= 64'd0;
            bus.E_val_a   <= 64'd0;
            bus.E_val_b   <= 64'd0;
            bus.E_dst_e   <= RNONE;
            bus.E_dst_m   <= RNONE;
            bus.E_src_a   <= RNONE;
            bus.E_src_b   <= RNONE;
        end else begin
            bus.E_stat    <= bus.D_stat;
            bus.E_in_code <= bus.D_in_code;
            bus.E_in_fun  <= bus.D_in_fun;
            bus.E_val_c   <= bus.D_val_c;
            bus.E_val_a   <= val_a;
            bus.E_val_b   <= val_b;
            bus.E_dst_e   <= dst_e;
            bus.E_dst_m   <= dst_m;
            bus.E_src_a   <= src_a;
            bus.E_src_b   <= src_b;
        end
    end
endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: scoreboard of expected E-register contents per clock edge.
// Expectations come from a bench-side register file and decode tables.
// Build with or without DECODE_FWD_EN; operand expectations follow the same macro.
module tb_decode_pipe;
    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  code;
        logic [3:0]  fun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
    } e_t;

    localparam logic [3:0] F = 4'hF;
    localparam e_t BUBBLE = '{stat: 2'b00, code: 4'h1, fun: 4'h0, valc: 64'd0,
                              vala: 64'd0, valb: 64'd0, dste: F, dstm: F,
                              srca: F, srcb: F};

    logic clock;
    logic reset;
    decode_pipe_if bus ();

    decode_pipe #(.STACK_INIT(64'd1000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   passed = 0;
    int   total  = 0;
    e_t   sbq [$];
    logic [63:0] mrf [0:15];

    function automatic e_t dut_e();
        return {bus.E_stat, bus.E_in_code, bus.E_in_fun, bus.E_val_c,
                bus.E_val_a, bus.E_val_b, bus.E_dst_e, bus.E_dst_m,
                bus.E_src_a, bus.E_src_b};
    endfunction

    // Decode tables for the Y86-64 instruction set
    function automatic logic [3:0] t_src_a(input logic [3:0] c, input logic [3:0] ra);
        if (c == 4'h2 || c == 4'h4 || c == 4'h6 || c == 4'hA) return ra;
        if (c == 4'h9 || c == 4'hB) return 4'h4;
        return F;
    endfunction
    function automatic logic [3:0] t_src_b(input logic [3:0] c, input logic [3:0] rb);
        if (c == 4'h4 || c == 4'h5 || c == 4'h6) return rb;
        if (c >= 4'h8 && c <= 4'hB) return 4'h4;
        return F;
    endfunction
    function automatic logic [3:0] t_dst_e(input logic [3:0] c, input logic [3:0] rb);
        if (c == 4'h2 || c == 4'h3 || c == 4'h6) return rb;
        if (c >= 4'h8 && c <= 4'hB) return 4'h4;
        return F;
    endfunction
    function automatic logic [3:0] t_dst_m(input logic [3:0] c, input logic [3:0] ra);
        if (c == 4'h5 || c == 4'hB) return ra;
        return F;
    endfunction

    function automatic logic [63:0] operand(input logic [3:0] s);
        logic [63:0] v;
        v = (s == F) ? 64'd0 : mrf[s];
`ifdef DECODE_FWD_EN
        if (s != F) begin
            if      (s == bus.e_dst_e) v = bus.e_val_e;
            else if (s == bus.M_dst_m) v = bus.m_val_m;
            else if (s == bus.M_dst_e) v = bus.M_val_e;
            else if (s == bus.W_dst_m) v = bus.W_val_m;
            else if (s == bus.W_dst_e) v = bus.W_val_e;
        end
`endif
        return v;
    endfunction

    function automatic e_t model_next();
        e_t r;
        logic [3:0] c;
        if (bus.E_bub) return BUBBLE;
        c      = bus.D_in_code;
        r.stat = bus.D_stat;
        r.code = c;
        r.fun  = bus.D_in_fun;
        r.valc = bus.D_val_c;
        r.srca = t_src_a(c, bus.D_ra);
        r.srcb = t_src_b(c, bus.D_rb);
        r.dste = t_dst_e(c, bus.D_rb);
        r.dstm = t_dst_m(c, bus.D_ra);
        r.vala = (c == 4'h7 || c == 4'h8) ? bus.D_val_p : operand(r.srca);
        r.valb = operand(r.srcb);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mrf[i] = (i == 4) ? 64'd1000 : 64'd0;
    endtask

    // Push the expected E contents, take one edge, apply the write-back to the model
    task automatic cycle();
        sbq.push_back(model_next());
        @(posedge clock);
        if (bus.W_dst_e != F) mrf[bus.W_dst_e] = bus.W_val_e;
        if (bus.W_dst_m != F) mrf[bus.W_dst_m] = bus.W_val_m;
        #1;
    endtask

    task automatic set_idle();
        bus.D_stat = 2'b00; bus.D_in_code = 4'h1; bus.D_in_fun = 4'h0;
        bus.D_ra = F; bus.D_rb = F; bus.D_val_c = 64'd0; bus.D_val_p = 64'd0;
        bus.e_dst_e = F; bus.e_val_e = 64'd0;
        bus.M_dst_e = F; bus.M_val_e = 64'd0; bus.M_dst_m = F; bus.m_val_m = 64'd0;
        bus.W_dst_e = F; bus.W_val_e = 64'd0; bus.W_dst_m = F; bus.W_val_m = 64'd0;
        bus.E_bub = 1'b0;
    endtask

    task automatic test_reset();
        e_t got, exp;
        set_idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        got = dut_e();
        total++;
        if (got !== BUBBLE) $display("FAIL reset_state got=%h exp=%h", got, BUBBLE);
        else passed++;
        reset = 1'b0;
        cycle();
        exp = sbq.pop_front(); got = dut_e();
        total++;
        if (got !== exp || got.vala !== 64'd0 || got.dste !== F || got.srca !== F)
            $display("FAIL first_nop got=%h exp=%h", got, exp);
        else passed++;
        bus.D_in_code = 4'h9;
        cycle();
        exp = sbq.pop_front(); got = dut_e();
        total++;
        if (got !== exp || got.vala !== 64'd1000 || got.valb !== 64'd1000)
            $display("FAIL rsp_init got=%h exp=%h", got, exp);
        else passed++;
        // every other register reads zero after reset
        for (int r = 0; r < 15; r++) begin
            bus.D_in_code = 4'h2; bus.D_ra = r[3:0];
            cycle();
            exp = sbq.pop_front(); got = dut_e();
            total++;
            if (got !== exp || got.vala !== ((r == 4) ? 64'd1000 : 64'd0))
                $display("FAIL reset_reg%0d got=%h exp=%h", r, got.vala, exp.vala);
            else passed++;
        end
        set_idle();
    endtask

    task automatic test_regwrite();
        e_t got, exp;
        bus.W_dst_e = 4'h2; bus.W_val_e = 64'h55;
        cycle();
        void'(sbq.pop_front());
        set_idle();
        bus.D_in_code = 4'h6; bus.D_ra = 4'h2; bus.D_rb = 4'h2;
        cycle();
        exp = sbq.pop_front(); got = dut_e();
        total++;
        if (got !== exp || got.vala !== 64'h55 || got.valb !== 64'h55 || got.dste !== 4'h2)
            $display("FAIL regwrite got=%h exp=%h", got, exp);
        else passed++;
        set_idle();
    endtask

    task automatic test_fwd_priority();
        e_t got, exp;
        logic [63:0] want;
        bus.W_dst_e = 4'h3; bus.W_val_e = 64'h33;
        bus.W_dst_m = 4'h1; bus.W_val_m = 64'h11;
        cycle();
        void'(sbq.pop_front());
        set_idle();
        bus.e_dst_e = 4'h3; bus.e_val_e = 64'd7;
        bus.M_dst_e = 4'h3; bus.M_val_e = 64'd9;
        bus.D_in_code = 4'h2; bus.D_ra = 4'h3;
`ifdef DECODE_FWD_EN
        want = 64'd7;
`else
        want = 64'h33;
`endif
        cycle();
        exp = sbq.pop_front(); got = dut_e();
        total++;
        if (got !== exp || got.vala !== want)
            $display("FAIL fwd_priority got=%h exp=%h", got.vala, want);
        else passed++;
        set_idle();
    endtask

    task automatic test_dual_write();
        e_t got, exp;
        bus.W_dst_e = 4'h5; bus.W_val_e = 64'd1;
        bus.W_dst_m = 4'h5; bus.W_val_m = 64'd2;
        cycle();
        void'(sbq.pop_front());
        set_idle();
        bus.D_in_code = 4'h6; bus.D_ra = 4'h5; bus.D_rb = 4'h5;
        cycle();
        exp = sbq.pop_front(); got = dut_e();
        total++;
        if (got !== exp || got.vala !== 64'd2 || got.valb !== 64'd2)
            $display("FAIL dual_write got=%h exp=%h", got.vala, 64'd2);
        else passed++;
        set_idle();
    endtask

    task automatic test_call();
        e_t got, exp;
        bus.D_in_code = 4'h8; bus.D_val_p = 64'h20; bus.D_val_c = 64'h100;
        cycle();
        exp = sbq.pop_front(); got = dut_e();
        total++;
        if (got !== exp || got.vala !== 64'h20 || got.srcb !== 4'h4 ||
            got.dste !== 4'h4 || got.dstm !== F || got.valb !== 64'd1000)
            $display("FAIL call got=%h exp=%h", got, exp);
        else passed++;
        set_idle();
    endtask

    task automatic test_bubble();
        e_t got, exp;
        logic [63:0] want;
        bus.E_bub = 1'b1;
        bus.D_in_code = 4'h5; bus.D_ra = 4'h1; bus.D_rb = 4'h2;
        cycle();
        exp = sbq.pop_front(); got = dut_e();
        total++;
        if (got !== exp || got !== BUBBLE)
            $display("FAIL bubble got=%h exp=%h", got, BUBBLE);
        else passed++;
        bus.E_bub = 1'b0;
        bus.D_in_code = 4'h2; bus.e_dst_e = 4'h1; bus.e_val_e = 64'hDEAD;
`ifdef DECODE_FWD_EN
        want = 64'hDEAD;
`else
        want = 64'h11;
`endif
        cycle();
        exp = sbq.pop_front(); got = dut_e();
        total++;
        if (got !== exp || got.vala !== want)
            $display("FAIL after_bubble got=%h exp=%h", got.vala, want);
        else passed++;
        set_idle();
    endtask

    task automatic test_decode_table();
        e_t got, exp;
        for (int c = 0; c < 16; c++) begin
            bus.D_in_code = c[3:0]; bus.D_in_fun = 4'(15 - c);
            bus.D_ra = 4'h6; bus.D_rb = 4'h7; bus.D_stat = c[1:0];
            bus.D_val_c = 64'(c) << 8; bus.D_val_p = 64'(c) + 64'h40;
            #1;
            total++;
            if (bus.d_src_a !== t_src_a(c[3:0], 4'h6) || bus.d_src_b !== t_src_b(c[3:0], 4'h7))
                $display("FAIL src_ids code=%0d got=%h/%h exp=%h/%h", c, bus.d_src_a,
                         bus.d_src_b, t_src_a(c[3:0], 4'h6), t_src_b(c[3:0], 4'h7));
            else passed++;
            cycle();
            exp = sbq.pop_front(); got = dut_e();
            total++;
            if (got !== exp) $display("FAIL decode code=%0d got=%h exp=%h", c, got, exp);
            else passed++;
        end
        set_idle();
    endtask

    task automatic test_back_to_back();
        e_t got, exp;
        int errs;
        errs = 0;
        for (int n = 0; n < 40; n++) begin
            bus.D_stat = 2'($urandom_range(0, 3));
            bus.D_in_code = 4'($urandom_range(0, 15)); bus.D_in_fun = 4'($urandom_range(0, 15));
            bus.D_ra = 4'($urandom_range(0, 15)); bus.D_rb = 4'($urandom_range(0, 15));
            bus.D_val_c = {$urandom, $urandom}; bus.D_val_p = {$urandom, $urandom};
            bus.e_dst_e = 4'($urandom_range(0, 15)); bus.e_val_e = {$urandom, $urandom};
            bus.M_dst_e = 4'($urandom_range(0, 15)); bus.M_val_e = {$urandom, $urandom};
            bus.M_dst_m = 4'($urandom_range(0, 15)); bus.m_val_m = {$urandom, $urandom};
            bus.W_dst_e = 4'($urandom_range(0, 15)); bus.W_val_e = {$urandom, $urandom};
            bus.W_dst_m = 4'($urandom_range(0, 15)); bus.W_val_m = {$urandom, $urandom};
            bus.E_bub = ($urandom_range(0, 5) == 0);
            if (n == 20) begin
                // asynchronous reset mid-program, away from the clock edge
                #2 reset = 1'b1;
                #1;
                model_reset();
                got = dut_e();
                total++;
                if (got !== BUBBLE) $display("FAIL async_reset got=%h exp=%h", got, BUBBLE);
                else passed++;
                reset = 1'b0;
                bus.E_bub = 1'b0;
            end
            cycle();
            exp = sbq.pop_front(); got = dut_e();
            total++;
            if (got !== exp) begin
                errs++;
                if (errs < 8) $display("FAIL b2b n=%0d got=%h exp=%h", n, got, exp);
            end else passed++;
        end
        set_idle();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        test_reset();
        test_regwrite();
        test_fwd_priority();
        test_dual_write();
        test_call();
        test_bubble();
        test_decode_table();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
